// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing: raster counters, fixed-latency pixel fetch and sync-aligned RGB output
// for three TMDS encoders, with an optional internal colour-bar source.
module hdmi_video_timing #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int FETCH_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pattern_en,
    output logic        pix_req,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    input  logic [23:0] pix_data,
    output logic        disp_en,
    output logic        hsync,
    output logic        vsync,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BW      = H_ACTIVE / 8;
    localparam logic [10:0] HA  = 11'(H_ACTIVE);
    localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] HT1 = 11'(H_TOTAL - 1);
    localparam logic [10:0] VA  = 11'(V_ACTIVE);
    localparam logic [10:0] VS0 = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] VT1 = 11'(V_TOTAL - 1);
    localparam logic HP = 1'(HS_POL);
    localparam logic VP = 1'(VS_POL);
    localparam logic [7:0][23:0] BARS = {24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
                                         24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF};

    typedef struct packed {
        logic        act;
        logic        hs;
        logic        vs;
        logic        ff;
        logic [10:0] x;
    } stage_t;

    logic [10:0] hc_q, hc_d, vc_q, vc_d, pix_y_q;
    logic        act, hs, vs, ff, pat_q;
    logic        de_q, hs_q, vs_q, fs_q;
    logic [2:0]  bar;
    logic [23:0] rgb_d, rgb_q;
    stage_t      pipe_q [FETCH_LAT+1];
    stage_t      last;

    always_comb begin
        hc_d = (hc_q == HT1) ? 11'd0 : hc_q + 11'd1;
        vc_d = (hc_q != HT1) ? vc_q : (vc_q == VT1) ? 11'd0 : vc_q + 11'd1;
        act  = (hc_q < HA) && (vc_q < VA);
        hs   = (hc_q >= HS0) && (hc_q < HS1);
        vs   = (vc_q >= VS0) && (vc_q < VS1);
        ff   = (hc_q == 11'd0) && (vc_q == 11'd0);
    end

    assign last = pipe_q[FETCH_LAT];

    // Bar index by comparator chain; columns past the last full bar stay on bar 7.
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++)
            if (last.x >= 11'(k * BW)) bar = 3'(k);
        rgb_d = !last.act ? 24'h0 : pat_q ? BARS[bar] : pix_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hc_q    <= '0;
            vc_q    <= '0;
            pix_y_q <= '0;
            pat_q   <= 1'b0;
            for (int i = 0; i <= FETCH_LAT; i++) pipe_q[i] <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~HP;
            vs_q    <= ~VP;
            fs_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            pipe_q[0] <= '{act: act, hs: hs, vs: vs, ff: ff, x: act ? hc_q : 11'd0};
            pix_y_q   <= act ? vc_q : 11'd0;
            for (int i = 1; i <= FETCH_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            if (ff) pat_q <= pattern_en;
            de_q  <= last.act;
            hs_q  <= last.hs ? HP : ~HP;
            vs_q  <= last.vs ? VP : ~VP;
            fs_q  <= last.ff;
            rgb_q <= rgb_d;
        end
    end

    assign pix_req             = pipe_q[0].act;
    assign pix_x               = pipe_q[0].x;
    assign pix_y               = pix_y_q;
    assign disp_en             = de_q;
    assign hsync               = hs_q;
    assign vsync               = vs_q;
    assign frame_start         = fs_q;
    assign {red, green, blue}  = rgb_q;
endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb_hdmi_video_timing: table-driven check of raster timing, fetch alignment, colour bars
// and reset behaviour on a reduced 28x11 raster (20x6 active, 2-pixel bars).
module tb_hdmi_video_timing;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pattern_en = 1'b0;
    logic        pix_req;
    logic [10:0] pix_x, pix_y;
    logic [23:0] pix_data;
    logic        disp_en, hsync, vsync, frame_start;
    logic [7:0]  red, green, blue;

    int n_chk = 0;
    int n_fail = 0;
    int cur = 0;
    int fs_cnt = 0, vs_low = 0, hs_low = 0, de_cnt = 0;

    hdmi_video_timing #(
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .HS_POL(0), .VS_POL(0), .FETCH_LAT(2)
    ) dut (
        .clk(clk), .reset(reset), .pattern_en(pattern_en),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .disp_en(disp_en), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Frame source: answers each request two clocks later, junk outside request slots.
    logic        d1_v = 1'b0, d2_v = 1'b0;
    logic [10:0] d1_x = '0, d1_y = '0, d2_x = '0, d2_y = '0;
    always @(posedge clk) begin
        d1_v <= pix_req; d1_x <= pix_x; d1_y <= pix_y;
        d2_v <= d1_v;    d2_x <= d1_x;  d2_y <= d1_y;
    end
    assign pix_data = d2_v ? {d2_x[7:0], d2_y[7:0], 8'hA5} : 24'hDEADBE;

    always @(negedge clk) begin
        if (reset) begin
            fs_cnt += frame_start ? 1 : 0;
            vs_low += vsync ? 0 : 1;
            hs_low += hsync ? 0 : 1;
            de_cnt += disp_en ? 1 : 0;
        end
    end

    typedef struct {
        int          k;
        logic        pat;
        logic        req;
        logic [10:0] x;
        logic [10:0] y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [23:0] rgb;
    } vec_t;
    vec_t vt[$];

    task automatic add(input int k, input logic pat, input logic req, input int x, input int y,
                       input logic de, input logic hs, input logic vs, input logic fs,
                       input logic [23:0] rgb);
        vt.push_back('{k, pat, req, 11'(x), 11'(y), de, hs, vs, fs, rgb});
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pix_req"}, 32'(pix_req), 32'd0);
        chk({tag, " pix_x"}, 32'(pix_x), 32'd0);
        chk({tag, " pix_y"}, 32'(pix_y), 32'd0);
        chk({tag, " disp_en"}, 32'(disp_en), 32'd0);
        chk({tag, " hsync"}, 32'(hsync), 32'd1);
        chk({tag, " vsync"}, 32'(vsync), 32'd1);
        chk({tag, " frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, " rgb"}, 32'({red, green, blue}), 32'd0);
    endtask

    // k counts rising edges since reset release; outputs sampled 1 time unit after edge k.
    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            pattern_en = vt[i].pat;
            repeat (vt[i].k - cur) @(posedge clk);
            cur = vt[i].k;
            #1;
            chk($sformatf("k%0d pix_req", cur), 32'(pix_req), 32'(vt[i].req));
            chk($sformatf("k%0d pix_x", cur), 32'(pix_x), 32'(vt[i].x));
            chk($sformatf("k%0d pix_y", cur), 32'(pix_y), 32'(vt[i].y));
            chk($sformatf("k%0d disp_en", cur), 32'(disp_en), 32'(vt[i].de));
            chk($sformatf("k%0d hsync", cur), 32'(hsync), 32'(vt[i].hs));
            chk($sformatf("k%0d vsync", cur), 32'(vsync), 32'(vt[i].vs));
            chk($sformatf("k%0d frame_start", cur), 32'(frame_start), 32'(vt[i].fs));
            chk($sformatf("k%0d rgb", cur), 32'({red, green, blue}), 32'(vt[i].rgb));
        end
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        //   k   pat req  x  y  de hs vs fs  rgb
        add(1,   0, 1,  0, 0, 0, 1, 1, 0, 24'h000000);
        add(3,   0, 1,  2, 0, 0, 1, 1, 0, 24'h000000);
        add(4,   0, 1,  3, 0, 1, 1, 1, 1, 24'h0000A5);
        add(5,   0, 1,  4, 0, 1, 1, 1, 0, 24'h0100A5);
        add(23,  0, 0,  0, 0, 1, 1, 1, 0, 24'h1300A5);
        add(24,  0, 0,  0, 0, 0, 1, 1, 0, 24'h000000);
        add(25,  0, 0,  0, 0, 0, 1, 1, 0, 24'h000000);
        add(26,  0, 0,  0, 0, 0, 0, 1, 0, 24'h000000);
        add(28,  0, 0,  0, 0, 0, 0, 1, 0, 24'h000000);
        add(29,  0, 1,  0, 1, 0, 1, 1, 0, 24'h000000);
        add(32,  0, 1,  3, 1, 1, 1, 1, 0, 24'h0001A5);
        add(93,  0, 1,  8, 3, 1, 1, 1, 0, 24'h0503A5);
        add(163, 0, 0,  0, 0, 1, 1, 1, 0, 24'h1305A5);
        add(172, 0, 0,  0, 0, 0, 1, 1, 0, 24'h000000);
        add(199, 0, 0,  0, 0, 0, 1, 1, 0, 24'h000000);
        add(200, 0, 0,  0, 0, 0, 1, 0, 0, 24'h000000);
        add(255, 0, 0,  0, 0, 0, 1, 0, 0, 24'h000000);
        add(256, 0, 0,  0, 0, 0, 1, 1, 0, 24'h000000);
        add(311, 0, 1,  2, 0, 0, 1, 1, 0, 24'h000000);
        add(312, 0, 1,  3, 0, 1, 1, 1, 1, 24'h0000A5);
        add(313, 0, 1,  4, 0, 1, 1, 1, 0, 24'h0100A5);
        add(401, 1, 1,  8, 3, 1, 1, 1, 0, 24'h0503A5);
        add(620, 1, 1,  3, 0, 1, 1, 1, 1, 24'hFFFFFF);
        add(622, 1, 1,  5, 0, 1, 1, 1, 0, 24'hFFFF00);
        add(624, 1, 1,  7, 0, 1, 1, 1, 0, 24'h00FFFF);
        add(630, 0, 1, 13, 0, 1, 1, 1, 0, 24'hFF0000);
        add(633, 0, 1, 16, 0, 1, 1, 1, 0, 24'h0000FF);
        add(639, 0, 0,  0, 0, 1, 1, 1, 0, 24'h000000);
        add(640, 0, 0,  0, 0, 0, 1, 1, 0, 24'h000000);
        add(657, 0, 1, 12, 1, 1, 1, 1, 0, 24'hFF00FF);
        add(928, 0, 1,  3, 0, 1, 1, 1, 1, 24'h0000A5);

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("in_reset");
        @(negedge clk);
        reset = 1'b1;
        cur = 0;
        #1;
        chk("release pix_req", 32'(pix_req), 32'd0);
        run_vecs(0, vt.size() - 1);

        @(negedge clk);
        #1;
        chk("frame_start pulses", 32'(fs_cnt), 32'd4);
        chk("vsync low clocks", 32'(vs_low), 32'd168);
        chk("hsync low clocks", 32'(hs_low), 32'd99);
        chk("disp_en clocks", 32'(de_cnt), 32'd361);

        repeat (994 - cur) @(posedge clk);
        #1;
        chk("pre_reset disp_en", 32'(disp_en), 32'd1);
        chk("pre_reset rgb", 32'({red, green, blue}), 32'h0A02A5);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        chk_reset_outputs("held_reset");
        @(negedge clk);
        reset = 1'b1;
        cur = 0;
        run_vecs(0, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
